// File: rtl/spi_pkg.sv
// Shared frame layout, pin indices and receiver state encoding for the SPI
// front end that feeds the register writer.
package spi_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;

  localparam int SCLK = 0;
  localparam int COPI = 1;
  localparam int NCS  = 2;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop pin synchronizer with registered previous value for rise/fall
// detection; reset level matches the pin's idle state so reset causes no edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_LVL}};
      prev <= RST_LVL;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_frame_rx.sv
// Mode-0, MSB-first SPI frame receiver: synchronizes the raw pins, shifts in
// frames while nCS is low, and hands good frames to a one-entry valid/ready buffer.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = spi_pkg::ADDR_W,
  parameter int DATA_W      = spi_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_pin,
  input  logic              copi_pin,
  input  logic              ncs_pin,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_rw,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              overflow,
  input  logic              ovf_clr
);

  import spi_pkg::*;

  localparam int NBITS = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(NBITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBITS + 1);
  // Idle levels: SCLK low, COPI low, nCS high.
  localparam logic [2:0] IDLE_LVL = 3'b100;

  logic [2:0] pins;
  logic [2:0] pins_s;
  logic [2:0] rise;
  logic [2:0] fall;

  assign pins = {ncs_pin, copi_pin, sclk_pin};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_LVL (IDLE_LVL[i])
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .pin   (pins[i]),
      .level (pins_s[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = &{1'b0, rise[COPI], fall[COPI], fall[SCLK], pins_s[SCLK], pins_s[NCS]};

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [NBITS-1:0] shreg;
  logic             shift_en;
  logic             frame_end;
  logic             good;
  logic             buf_free;
  logic             load;
  logic             drop;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall[NCS]) state_d = SHIFT;
      end
      SHIFT: begin
        shift_en  = rise[SCLK];
        frame_end = rise[NCS];
        if (rise[NCS]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign good     = frame_end && (cnt == CNT_FULL);
  assign buf_free = !frame_valid || frame_ready;
  assign load     = good && buf_free;
  assign drop     = good && !buf_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (fall[NCS]) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[NBITS-2:0], pins_s[COPI]};
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  // Output fields only change on load, so they hold after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_rw    <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_err <= frame_end && (cnt != CNT_FULL);
      if (load) begin
        frame_valid <= 1'b1;
        frame_rw    <= shreg[NBITS-1];
        frame_addr  <= shreg[NBITS-2 -: ADDR_W];
        frame_data  <= shreg[DATA_W-1:0];
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: bit-banged SPI frames against hand-computed
// expected frames, error pulses and overflow behaviour.
module tb_spi_frame_rx;
  import spi_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk_pin, copi_pin, ncs_pin;
  logic              frame_valid, frame_ready;
  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_err, overflow, ovf_clr;

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_pin    (sclk_pin),
    .copi_pin    (copi_pin),
    .ncs_pin     (ncs_pin),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_rw    (frame_rw),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observed activity, gathered on the falling edge.
  int          valid_cycles = 0;
  int          valid_drops  = 0;
  int          err_cycles   = 0;
  int          err_pulses   = 0;
  logic [15:0] acc_q[$];
  logic        pv = 1'b0;
  logic        pe = 1'b0;

  always @(negedge clk) begin
    if (frame_valid && frame_ready) acc_q.push_back({frame_rw, frame_addr, frame_data});
    if (frame_valid === 1'b1) valid_cycles++;
    if (pv && frame_valid === 1'b0) valid_drops++;
    if (frame_err === 1'b1) err_cycles++;
    if (!pe && frame_err === 1'b1) err_pulses++;
    pv = (frame_valid === 1'b1);
    pe = (frame_err === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    ncs_pin = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi_pin = v[i];
      tick(4);
      sclk_pin = 1'b1;
      tick(4);
      sclk_pin = 1'b0;
    end
  endtask

  // pulse_ready raises frame_ready only in the cycle the nCS rise is acted on.
  task automatic cs_high(input bit pulse_ready);
    tick(4);
    ncs_pin = 1'b1;
    if (pulse_ready) begin
      tick(2);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
    end
    tick(8);
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    cs_low();
    send_bits(v, n);
    cs_high(1'b0);
  endtask

  int e0, v0, d0, n0;

  initial begin
    rst = 1'b1; sclk_pin = 1'b0; copi_pin = 1'b0; ncs_pin = 1'b1;
    frame_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_rw",    32'(frame_rw),    32'h0);
    check("rst_addr",  32'(frame_addr),  32'h0);
    check("rst_data",  32'(frame_data),  32'h0);
    check("rst_err",   32'(frame_err),   32'h0);
    check("rst_ovf",   32'(overflow),    32'h0);

    // Good write frame, consumer always ready
    frame_ready = 1'b1;
    send_frame(32'h8155, 16);
    check("w1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("w1_count",        32'(acc_q.size()), 32'd1);
    check("w1_frame",        32'(acc_q[$]),     32'h8155);
    check("w1_rw_hold",      32'(frame_rw),     32'h1);
    check("w1_addr_hold",    32'(frame_addr),   32'h01);
    check("w1_data_hold",    32'(frame_data),   32'h55);
    check("w1_err",          32'(err_cycles),   32'd0);
    check("w1_ovf",          32'(overflow),     32'h0);

    // Short and long frames
    e0 = err_pulses; v0 = valid_cycles;
    send_frame(32'h1234, 15);
    check("short_err", 32'(err_pulses), 32'(e0 + 1));
    send_frame(32'h1ABCD, 17);
    check("long_err",      32'(err_pulses),   32'(e0 + 2));
    check("err_one_cycle", 32'(err_cycles),   32'(err_pulses));
    check("len_no_valid",  32'(valid_cycles), 32'(v0));

    // Overflow while the consumer stalls
    frame_ready = 1'b0;
    send_frame(32'h8155, 16);
    check("ov_first_valid", 32'(frame_valid), 32'h1);
    check("ov_first_ovf",   32'(overflow),    32'h0);
    send_frame(32'h02AA, 16);
    check("ov_valid", 32'(frame_valid), 32'h1);
    check("ov_rw",    32'(frame_rw),    32'h1);
    check("ov_addr",  32'(frame_addr),  32'h01);
    check("ov_data",  32'(frame_data),  32'h55);
    check("ov_set",   32'(overflow),    32'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    check("ov_clr",       32'(overflow),   32'h0);
    check("ov_clr_addr",  32'(frame_addr), 32'h01);
    check("ov_clr_data",  32'(frame_data), 32'h55);

    // Accept and reload in the same frame-end cycle
    d0 = valid_drops; n0 = acc_q.size();
    cs_low();
    send_bits(32'h8310, 16);
    cs_high(1'b1);
    check("rl_valid",   32'(frame_valid),  32'h1);
    check("rl_nodrop",  32'(valid_drops),  32'(d0));
    check("rl_acc_cnt", 32'(acc_q.size()), 32'(n0 + 1));
    check("rl_acc",     32'(acc_q[$]),     32'h8155);
    check("rl_rw",      32'(frame_rw),     32'h1);
    check("rl_addr",    32'(frame_addr),   32'h03);
    check("rl_data",    32'(frame_data),   32'h10);
    check("rl_ovf",     32'(overflow),     32'h0);
    frame_ready = 1'b1;
    tick(2);
    check("rl_drain",       32'(acc_q[$]),    32'h8310);
    check("rl_drain_valid", 32'(frame_valid), 32'h0);

    // SCLK noise while deselected, then a good frame
    n0 = acc_q.size(); e0 = err_pulses;
    for (int i = 0; i < 20; i++) begin
      copi_pin = i[0];
      sclk_pin = 1'b1;
      tick(4);
      sclk_pin = 1'b0;
      tick(4);
    end
    send_frame(32'h847F, 16);
    check("idle_cnt",  32'(acc_q.size()), 32'(n0 + 1));
    check("idle_acc",  32'(acc_q[$]),     32'h847F);
    check("idle_rw",   32'(frame_rw),     32'h1);
    check("idle_addr", 32'(frame_addr),   32'h04);
    check("idle_data", 32'(frame_data),   32'h7F);
    check("idle_err",  32'(err_pulses),   32'(e0));

    // Reset mid-frame with nCS held low
    n0 = acc_q.size(); e0 = err_pulses; v0 = valid_cycles;
    cs_low();
    send_bits(32'hA5, 8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_bits(32'h3C, 8);
    cs_high(1'b0);
    check("mid_err",      32'(err_pulses),   32'(e0 + 1));
    check("mid_err_len",  32'(err_cycles),   32'(err_pulses));
    check("mid_no_valid", 32'(valid_cycles), 32'(v0));
    check("mid_no_acc",   32'(acc_q.size()), 32'(n0));
    check("mid_valid",    32'(frame_valid),  32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
